// File: rtl/fp_add_pkg.sv
// Shared constants and the stage-1 record type for the floating-point adder.
package fp_add_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned EXP_MAX = 255;

  // Bit positions within out_flags.
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_UNF  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] mant;
    logic [4:0]  lz;
    logic        nz;
  } s1_rec_t;

endpackage

// File: rtl/priority_enc.sv
// 24-bit leading-one encoder: decoded is the number of zeros above the highest set bit.
module priority_enc (
  input  logic [23:0] in_vec,
  output logic [4:0]  decoded,
  output logic        triggered
);

  always_comb begin
    decoded   = 5'd0;
    triggered = |in_vec;
    // Scan upward so the highest set bit is the last to write.
    for (int unsigned i = 0; i < 24; i++) begin
      if (in_vec[i]) decoded = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_add_normalize.sv
// Post-add normalization: strips the carry, left-justifies via priority_enc and packs the
// IEEE-754 single result through a two-stage valid/ready pipeline.
module fp_add_normalize #(
  parameter int unsigned EXP_W  = fp_add_pkg::EXP_W,
  parameter int unsigned MANT_W = fp_add_pkg::MANT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [MANT_W+1:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_result,
  output logic [2:0]              out_flags
);

  import fp_add_pkg::*;

  logic adv1, adv2;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_rec_t s1_q, s1_d;
  logic [EXP_W+MANT_W:0] result_q, result_d;
  logic [2:0] flags_q, flags_d;

  logic [MANT_W:0] m1;
  logic [EXP_W:0]  e1;
  logic [4:0]      enc_lz;
  logic            enc_nz;

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  always_comb begin
    if (in_mant[MANT_W+1]) begin
      m1 = in_mant[MANT_W+1:1];
      e1 = {1'b0, in_exp} + 9'd1;
    end else begin
      m1 = in_mant[MANT_W:0];
      e1 = {1'b0, in_exp};
    end
  end

  priority_enc u_priority_enc (
    .in_vec    (m1),
    .decoded   (enc_lz),
    .triggered (enc_nz)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      s1_d       = '{sign: in_sign, exp: e1, mant: m1, lz: enc_lz, nz: enc_nz};
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      flags_d    = 3'b000;
      if (!s1_q.nz) begin
        result_d            = '0;
        flags_d[FLAG_ZERO]  = 1'b1;
      end else if (s1_q.exp >= 9'(EXP_MAX)) begin
        result_d            = {s1_q.sign, 8'hFF, 23'h0};
        flags_d[FLAG_OVF]   = 1'b1;
      end else if (s1_q.exp <= {4'b0, s1_q.lz}) begin
        // No denormals: anything that would need one is flushed to signed zero.
        result_d            = {s1_q.sign, 31'h0};
        flags_d[FLAG_UNF]   = 1'b1;
      end else begin
        result_d = {s1_q.sign, 8'(s1_q.exp - {4'b0, s1_q.lz}), 23'(s1_q.mant << s1_q.lz)};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Randomized and directed bench for fp_add_normalize with an arithmetic reference model.
module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  logic samp_valid;
  logic samp_in_ready;
  logic [34:0] sb[$];

  always #5 clk = ~clk;

  fp_add_normalize dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Value-level model: scale the mantissa until its top bit sits at 2^23.
  function automatic logic [34:0] ref_norm(input logic s, input int e, input int m);
    int lz = 0;
    if (m >= (1 << 24)) begin
      m = m / 2;
      e = e + 1;
    end
    if (m == 0) return {3'b001, 32'h0};
    while (m < (1 << 23)) begin
      m  = m * 2;
      lz = lz + 1;
    end
    if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
    if (e <= lz) return {3'b010, s, 31'h0};
    return {3'b000, s, 8'(e - lz), 23'(m - (1 << 23))};
  endfunction

  task automatic step(input logic v, input logic s, input logic [7:0] e, input logic [24:0] m,
                      input logic rdy, input logic use_exp, input logic [34:0] exp_word);
    logic acc, emit;
    @(negedge clk);
    in_valid  = v;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    out_ready = rdy;
    #1;
    samp_valid    = out_valid;
    samp_in_ready = in_ready;
    acc  = v && in_ready;
    emit = out_valid && rdy;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        check_eq("result", out_result, sb[0][31:0]);
        check_eq("flags", 32'(out_flags), 32'(sb[0][34:32]));
      end
    end
    @(posedge clk);
    if (emit && sb.size() > 0) void'(sb.pop_front());
    if (acc) begin
      sb.push_back(use_exp ? exp_word : ref_norm(s, int'(e), int'(m)));
      n_acc++;
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 8'd0, 25'd0, rdy, 1'b0, 35'd0);
  endtask

  initial begin
    logic [7:0]  bp_e[4];
    logic [24:0] bp_m[4];
    logic        bp_s[4];
    int acc0;
    int k;

    reset_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    out_ready = 1'b1;
    #17;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_result", out_result, 32'd0);
    check_eq("rst_out_flags", 32'(out_flags), 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // 1.0 + 1.0 with latency check.
    step(1'b1, 1'b0, 8'd127, 25'h1000000, 1'b1, 1'b1, {3'b000, 32'h40000000});
    idle(1'b1);
    check_eq("lat_stage1", {31'b0, samp_valid}, 32'd0);
    idle(1'b1);
    check_eq("lat_stage2", {31'b0, samp_valid}, 32'd1);

    step(1'b1, 1'b0, 8'd130, 25'h0000001, 1'b1, 1'b1, {3'b000, 32'h35800000});
    step(1'b1, 1'b1, 8'd77,  25'h0000000, 1'b1, 1'b1, {3'b001, 32'h00000000});
    step(1'b1, 1'b1, 8'd254, 25'h1800000, 1'b1, 1'b1, {3'b100, 32'hFF800000});
    step(1'b1, 1'b0, 8'd3,   25'h0000010, 1'b1, 1'b1, {3'b010, 32'h00000000});
    step(1'b1, 1'b1, 8'd3,   25'h0000010, 1'b1, 1'b1, {3'b010, 32'h80000000});
    repeat (3) idle(1'b1);

    // Backpressure: only two values fit while the output is stalled.
    for (int i = 0; i < 4; i++) begin
      bp_s[i] = 1'($urandom);
      bp_e[i] = 8'($urandom_range(20, 200));
      bp_m[i] = 25'($urandom);
    end
    acc0 = n_acc;
    for (int c = 0; c < 6; c++) begin
      k = n_acc - acc0;
      step(k < 4, (k < 4) ? bp_s[k] : 1'b0, (k < 4) ? bp_e[k] : 8'd0,
           (k < 4) ? bp_m[k] : 25'd0, 1'b0, 1'b0, 35'd0);
    end
    check_eq("bp_accepts", 32'(n_acc - acc0), 32'd2);
    check_eq("bp_in_ready", {31'b0, samp_in_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      k = n_acc - acc0;
      step(k < 4, (k < 4) ? bp_s[k] : 1'b0, (k < 4) ? bp_e[k] : 8'd0,
           (k < 4) ? bp_m[k] : 25'd0, 1'b1, 1'b0, 35'd0);
      check_eq("bp_stream_valid", {31'b0, samp_valid}, 32'd1);
    end
    check_eq("bp_all_accepted", 32'(n_acc - acc0), 32'd4);
    repeat (3) idle(1'b1);

    // Reset with both stages full.
    step(1'b1, 1'b0, 8'd100, 25'h0400000, 1'b0, 1'b0, 35'd0);
    step(1'b1, 1'b1, 8'd90,  25'h0123456, 1'b0, 1'b0, 35'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("midrst_out_result", out_result, 32'd0);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle(1'b1);
      check_eq("post_rst_quiet", {31'b0, samp_valid}, 32'd0);
    end
    step(1'b1, 1'b0, 8'd130, 25'h0000001, 1'b1, 1'b1, {3'b000, 32'h35800000});
    idle(1'b1);
    check_eq("post_rst_lat1", {31'b0, samp_valid}, 32'd0);
    idle(1'b1);
    check_eq("post_rst_lat2", {31'b0, samp_valid}, 32'd1);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      logic [24:0] m;
      case ($urandom_range(0, 3))
        0: m = 25'($urandom);
        1: m = 25'($urandom) >> $urandom_range(1, 24);
        2: m = 25'h1000000 | 25'($urandom_range(0, 255));
        default: m = ($urandom_range(0, 3) == 0) ? 25'd0 : 25'($urandom_range(1, 64));
      endcase
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), m,
           1'($urandom_range(0, 2) != 0), 1'b0, 35'd0);
    end

    for (int c = 0; c < 10 && sb.size() > 0; c++) idle(1'b1);
    check_eq("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_add_normalize.md
Name: fp_add_normalize

Overview:
- Post-addition normalization stage of the single-precision floating-point adder.
- Consumes the raw sum from the mantissa add/subtract stage: sign, pre-normalization exponent, and a 25-bit mantissa with the carry-out at bit 24.
- Removes any carry, left-justifies the mantissa using the priority_enc leading-one encoder, adjusts the exponent, and packs an IEEE-754 single result.
- Two-stage valid/ready pipeline; full throughput; feeds the adder output register.

Parameters:
- EXP_W, 8, exponent width. Only 8 is supported.
- MANT_W, 23, stored fraction width. Only 23 is supported, because priority_enc is fixed at 24 bits.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream sum valid
- in_ready  output  1  stage can accept in_* this cycle
- in_sign  input  1  sign of sum
- in_exp  input  8  biased exponent before normalization
- in_mant  input  25  bit24 = carry-out, bit23 = hidden-bit position
- out_valid  output  1  out_result valid
- out_ready  input  1  downstream accepts
- out_result  output  32  {sign, exp[7:0], frac[22:0]}
- out_flags  output  3  {overflow, underflow, zero}

Behaviour:
- Reset (asynchronous, reset_n=0):
  - s1_valid=0, s2_valid=0.
  - out_result=0, out_flags=0, out_valid=0.
  - Any in-flight data is discarded; nothing is emitted after reset release until new input arrives.
- Handshake:
  - A transfer occurs when valid && ready on each side.
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1 (combinational, no skid buffer).
  - Payload registers load only when their stage advances; otherwise they hold.
  - out_result and out_flags stay stable while out_valid=1 && out_ready=0.
- Stage 1 (load when adv1; s1_valid <= in_valid):
  - If in_mant[24]=1: m1 = in_mant[24:1] (LSB truncated), e1 = {1'b0,in_exp}+1 (9-bit).
  - Else: m1 = in_mant[23:0], e1 = {1'b0,in_exp}.
  - m1 drives a priority_enc instance.
  - Register m1, e1, sign, lz = decoded (0..23), and nz = triggered.
- Stage 2 (load when adv2; s2_valid <= s1_valid). Checks are applied in priority order:
  - nz=0: result 0x00000000 (+0 regardless of sign); flags=001.
  - e1 >= 255: result {sign, 8'hFF, 23'h0} (infinity); flags=100.
  - e1 <= lz: result {sign, 31'h0} (flush to zero, no denormals); flags=010.
  - Otherwise: exp = e1 - lz (1..254); frac = (m1 << lz)[22:0]; flags=000.
- Latency: 2 cycles from input acceptance to out_valid when out_ready is held high.
- Throughput: one result per cycle.
- Order is preserved and no data is dropped under any out_ready pattern.
- Simultaneous accept and emit in the same cycle are legal in both stages.
- No rounding in this stage; truncation only.

Decomposition:
- fp_add_pkg constants:
  - EXP_W=8, MANT_W=23, EXP_MAX=255
  - FLAG_OVF=2, FLAG_UNF=1, FLAG_ZERO=0 (out_flags bit indices)
  - typedef for the {sign, exp9, mant24, lz5, nz} stage-1 record
- Sub-module: the existing priority_enc, instantiated once in stage 1. No new sub-module.

Test Plan:
- 1.0+1.0: sign=0, exp=127, mant=0x1000000 -> 2 cycles later out_result=0x40000000, flags=000.
- Cancellation: exp=130, mant=0x0000001 -> lz=23, exp 107 -> out_result=0x35800000, flags=000.
- Exact zero: sign=1, mant=0 -> 0x00000000, flags=001. Overflow: exp=254, mant=0x1800000, sign=1 -> 0xFF800000, flags=100.
- Underflow: exp=3, mant=0x0000010 (lz=19) -> 0x00000000 with sign 0, flags=010. Same input with sign=1 -> 0x80000000.
- Backpressure: stream 4 values with out_ready=0 for 6 cycles -> in_ready drops after 2 accepts. Outputs stay held stable; all 4 results appear in order once out_ready=1, one per cycle.
- Reset mid-flight: assert reset_n=0 with s1 and s2 both full -> out_valid=0 immediately. After release, no stale output appears; the next input emerges 2 cycles after acceptance.
